ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single PSRAM memory controller between three requesters: VIC-II video fetch (port 0), 6510 CPU (port 1) and loader/DMA (port 2). It latches one request at a time, drives the controller's request interface (CS, write, bank, address, write data) and waits for the controller's busy handshake to complete. It then returns read data and a one-cycle acknowledge to the granted requester. Port 0 has fixed top priority; ports 1 and 2 are served round-robin.

## Interface
Parameters:
- ACCEPT_TIMEOUT, 64: clkRAM cycles to wait for the controller to raise busy after CS before aborting the request.

Ports:
- clkRAM  in  1  RAM clock; the whole block is in this domain.
- reset  in  1  synchronous, active-high reset.
- i_req  in  3  per-port request level; bit n belongs to port n.
- i_write  in  3  per-port direction; 1 = write, 0 = read.
- i_bank  in  18  per-port bank; port n uses bits [6n+5:6n].
- i_addr  in  48  per-port address; port n uses bits [16n+15:16n].
- i_wdata  in  24  per-port write data; port n uses bits [8n+7:8n].
- o_ack  out  3  one-cycle completion pulse to the granted port.
- o_rdata  out  8  read data, shared; valid in the o_ack cycle of a read.
- o_grant  out  2  index of the port being served; 3 = none.
- o_mem_cs  out  1  request strobe to the memory controller.
- o_mem_write  out  1  latched direction.
- o_mem_bank  out  6  latched bank.
- o_mem_addr  out  16  latched address.
- o_mem_data  out  8  latched write data.
- i_mem_busy  in  1  controller busy; it is high during controller init and during each access.
- i_mem_dataRead  in  8  controller read data; valid once busy falls after a read.
- o_error  out  1  sticky accept-timeout flag; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESPOND.
- IDLE: requires i_mem_busy=0 and at least one i_req bit set.
  - Grant order: port 0 first. Otherwise the port named by the rr pointer (1 or 2) if it is requesting, else the other one.
  - Latch write, bank, addr and wdata of the granted port into the o_mem_* registers and set o_grant.
  - Next state: ISSUE.
- ISSUE: o_mem_cs=1; clear the timeout counter; go to WAIT_ACCEPT.
- WAIT_ACCEPT: o_mem_cs stays 1.
  - When i_mem_busy=1: go to WAIT_DONE; o_mem_cs=0 from that cycle.
  - If the counter reaches ACCEPT_TIMEOUT first: drop o_mem_cs, set o_error, force o_rdata=8'hFF, go to RESPOND.
- WAIT_DONE: wait for i_mem_busy=0. On that cycle, for a read, register i_mem_dataRead into o_rdata. Go to RESPOND.
- RESPOND: o_ack[grant]=1 for exactly one cycle.
  - If the served port was 1 or 2, set rr to the other port.
  - Set o_grant=3 and go to IDLE.
- rr pointer: changes only in RESPOND after serving port 1 or 2; grants to port 0 leave it unchanged.
- Request fields are latched once. Changes to i_req, i_addr etc. after the grant do not affect the transaction in flight.
- A requester that drops i_req before its ack still gets its transaction completed and still receives o_ack.
- A requester must drop i_req in the cycle after o_ack, or it will be granted again.
- o_mem_* fields other than cs hold their last value between transactions.
- Reset, at any time including mid-access:
  - State IDLE, o_ack=0, o_mem_cs=0, o_grant=3, o_rdata=0, o_error=0, rr=1, o_mem_write/bank/addr/data=0.
  - No ack is issued for an access aborted by reset.

## Timing
- Reaching RESPOND from i_mem_busy falling takes 2 cycles (one cycle to detect in WAIT_DONE, then RESPOND). An abort takes the path from WAIT_ACCEPT to RESPOND.
- Arbiter overhead per access: 4 cycles plus the time the controller holds busy.
- From i_req rising in IDLE (controller idle): o_mem_cs goes high 2 cycles later (IDLE→ISSUE registered).
- o_ack comes 1 cycle after busy is seen low.
- After RESPOND, IDLE can grant on the next cycle. Back-to-back throughput is therefore limited only by the controller's busy time plus 4 cycles.
- While i_mem_busy=1 in IDLE (controller init, ~15000 cycles), no grant is made and requests wait.
- Simultaneous requests are resolved in the single IDLE decision cycle. No grant is preempted once made.

## Test plan
- Single write, port 1 (bank=0, addr=49152, wdata=8'hAA); model busy high 3 cycles after CS for 40 cycles → o_mem_cs high until busy, o_mem_addr=49152, o_mem_data=8'hAA, o_mem_write=1, o_ack=3'b010 one cycle, o_error=0.
- Read, port 2 (addr=16'h1234); model returns 8'h5A when busy falls → o_ack=3'b100 with o_rdata=8'h5A in the same cycle.
- Ports 0, 1 and 2 all request at once, held until ack → service order 0, 1, 2. A repeated port 0 request keeps winning. Ports 1 and 2 alternate 1, 2, 1, 2 across 4 non-port-0 grants.
- Requests while the model holds busy=1 for 100 cycles after reset → no o_mem_cs until busy falls, then normal grant to the highest-priority requester.
- Model never raises busy → o_mem_cs high for ACCEPT_TIMEOUT cycles then low; o_ack pulse with o_rdata=8'hFF; o_error stays 1 through later successful accesses.
- reset asserted in WAIT_DONE → next cycle o_mem_cs=0, o_ack=0, o_grant=3, o_error=0. No ack for the aborted request; a fresh request is then served normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// Purpose: shares one PSRAM controller between video (port 0), CPU (port 1) and loader/DMA (port 2).
// Latency: request to CS 2 cycles; ack 1 cycle after busy is seen low; 4 cycles overhead per access.
// Backpressure: requests wait while the controller is busy; the grant is held until that port is acked.
//
// Ports:
//   clkRAM, reset                  clock and synchronous active-high reset
//   i_req/i_write/i_bank/i_addr/i_wdata  packed per-port request fields (port n in slice n)
//   o_ack, o_rdata, o_grant        one-hot completion pulse, shared read data, served port (3 = none)
//   o_mem_cs/write/bank/addr/data  controller request interface (fields hold between accesses)
//   i_mem_busy, i_mem_dataRead     controller handshake and read data
//   o_error                        sticky accept-timeout flag
module ram_arbiter #(
    parameter int ACCEPT_TIMEOUT = 64
) (
    input  logic        clkRAM,
    input  logic        reset,
    input  logic [2:0]  i_req,
    input  logic [2:0]  i_write,
    input  logic [17:0] i_bank,
    input  logic [47:0] i_addr,
    input  logic [23:0] i_wdata,
    output logic [2:0]  o_ack,
    output logic [7:0]  o_rdata,
    output logic [1:0]  o_grant,
    output logic        o_mem_cs,
    output logic        o_mem_write,
    output logic [5:0]  o_mem_bank,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_data,
    input  logic        i_mem_busy,
    input  logic [7:0]  i_mem_dataRead,
    output logic        o_error
);

    localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t      stateQ, stateD;
    logic [CW-1:0] cntQ, cntD;
    // 0: port 1 is preferred between ports 1/2; 1: port 2 is preferred
    logic        rrIsPort2Q, rrIsPort2D;
    logic [1:0]  pick;
    logic [1:0]  grantD;
    logic [2:0]  ackD;
    logic [7:0]  rdataD;
    logic        csD, writeD, errorD;
    logic [5:0]  bankD;
    logic [15:0] addrD;
    logic [7:0]  dataD;
    logic [CW-1:0] cntInc;

    assign cntInc = cntQ + CW'(1);

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        rrIsPort2D = rrIsPort2Q;
        pick       = 2'd0;
        grantD     = o_grant;
        ackD       = 3'b000;
        rdataD     = o_rdata;
        csD        = o_mem_cs;
        writeD     = o_mem_write;
        bankD      = o_mem_bank;
        addrD      = o_mem_addr;
        dataD      = o_mem_data;
        errorD     = o_error;

        case (stateQ)
            IDLE: begin
                if (!i_mem_busy && (i_req != 3'b000)) begin
                    if (i_req[0])
                        pick = 2'd0;
                    else if (!rrIsPort2Q)
                        pick = i_req[1] ? 2'd1 : 2'd2;
                    else
                        pick = i_req[2] ? 2'd2 : 2'd1;

                    case (pick)
                        2'd0: begin
                            writeD = i_write[0];
                            bankD  = i_bank[5:0];
                            addrD  = i_addr[15:0];
                            dataD  = i_wdata[7:0];
                        end
                        2'd1: begin
                            writeD = i_write[1];
                            bankD  = i_bank[11:6];
                            addrD  = i_addr[31:16];
                            dataD  = i_wdata[15:8];
                        end
                        default: begin
                            writeD = i_write[2];
                            bankD  = i_bank[17:12];
                            addrD  = i_addr[47:32];
                            dataD  = i_wdata[23:16];
                        end
                    endcase
                    grantD = pick;
                    stateD = ISSUE;
                end
            end

            ISSUE: begin
                csD    = 1'b1;
                cntD   = '0;
                stateD = WAIT_ACCEPT;
            end

            WAIT_ACCEPT: begin
                if (i_mem_busy) begin
                    csD    = 1'b0;
                    stateD = WAIT_DONE;
                end else if (cntInc == CW'(ACCEPT_TIMEOUT)) begin
                    // Controller never accepted: complete the request with a marker value
                    // so the requester is not left hanging.
                    csD    = 1'b0;
                    errorD = 1'b1;
                    rdataD = 8'hFF;
                    ackD   = 3'b001 << o_grant;
                    stateD = RESPOND;
                end else begin
                    cntD = cntInc;
                end
            end

            WAIT_DONE: begin
                if (!i_mem_busy) begin
                    if (!o_mem_write)
                        rdataD = i_mem_dataRead;
                    ackD   = 3'b001 << o_grant;
                    stateD = RESPOND;
                end
            end

            RESPOND: begin
                // Only CPU/loader grants move the pointer; video grants leave it alone.
                if (o_grant == 2'd1)
                    rrIsPort2D = 1'b1;
                else if (o_grant == 2'd2)
                    rrIsPort2D = 1'b0;
                grantD = 2'd3;
                stateD = IDLE;
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkRAM) begin
        if (reset) begin
            stateQ      <= IDLE;
            cntQ        <= '0;
            rrIsPort2Q  <= 1'b0;
            o_grant     <= 2'd3;
            o_ack       <= 3'b000;
            o_rdata     <= 8'h00;
            o_mem_cs    <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_bank  <= 6'd0;
            o_mem_addr  <= 16'd0;
            o_mem_data  <= 8'h00;
            o_error     <= 1'b0;
        end else begin
            stateQ      <= stateD;
            cntQ        <= cntD;
            rrIsPort2Q  <= rrIsPort2D;
            o_grant     <= grantD;
            o_ack       <= ackD;
            o_rdata     <= rdataD;
            o_mem_cs    <= csD;
            o_mem_write <= writeD;
            o_mem_bank  <= bankD;
            o_mem_addr  <= addrD;
            o_mem_data  <= dataD;
            o_error     <= errorD;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose: directed self-checking bench for ram_arbiter with a small behavioural controller model.
// Latency: n/a (bench).
// Backpressure: controller model raises busy a few cycles after CS, or never, or holds it forced.
module tb_ram_arbiter;

    localparam int TIMEOUT = 64;

    logic        clkRAM = 1'b0;
    logic        reset  = 1'b1;
    logic [2:0]  i_req   = '0;
    logic [2:0]  i_write = '0;
    logic [17:0] i_bank  = '0;
    logic [47:0] i_addr  = '0;
    logic [23:0] i_wdata = '0;
    logic [2:0]  o_ack;
    logic [7:0]  o_rdata;
    logic [1:0]  o_grant;
    logic        o_mem_cs;
    logic        o_mem_write;
    logic [5:0]  o_mem_bank;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_data;
    logic        i_mem_busy     = 1'b0;
    logic [7:0]  i_mem_dataRead = 8'h00;
    logic        o_error;

    int nChecks = 0;
    int nErrors = 0;

    ram_arbiter #(.ACCEPT_TIMEOUT(TIMEOUT)) dut (
        .clkRAM(clkRAM), .reset(reset),
        .i_req(i_req), .i_write(i_write), .i_bank(i_bank), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_ack(o_ack), .o_rdata(o_rdata), .o_grant(o_grant),
        .o_mem_cs(o_mem_cs), .o_mem_write(o_mem_write), .o_mem_bank(o_mem_bank),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .i_mem_busy(i_mem_busy), .i_mem_dataRead(i_mem_dataRead), .o_error(o_error)
    );

    always #5 clkRAM = ~clkRAM;

    // Controller model, updated on the falling edge so the arbiter sees stable inputs.
    int         mdlPhase  = 0;
    int         mdlCnt    = 0;
    int         mdlDelay  = 3;
    int         mdlLen    = 40;
    logic       mdlNever  = 1'b0;
    logic       forceBusy = 1'b0;
    logic [7:0] mdlData   = 8'h00;

    always @(negedge clkRAM) begin
        if (forceBusy) begin
            i_mem_busy = 1'b1;
            mdlPhase   = 0;
        end else begin
            case (mdlPhase)
                0: begin
                    i_mem_busy = 1'b0;
                    if (o_mem_cs && !mdlNever) begin
                        mdlPhase = 1;
                        mdlCnt   = 1;
                    end
                end
                1: begin
                    if (mdlCnt >= mdlDelay) begin
                        i_mem_busy = 1'b1;
                        mdlPhase   = 2;
                        mdlCnt     = 1;
                    end else begin
                        mdlCnt++;
                    end
                end
                default: begin
                    if (mdlCnt >= mdlLen) begin
                        i_mem_busy     = 1'b0;
                        i_mem_dataRead = mdlData;
                        mdlPhase       = 0;
                    end else begin
                        mdlCnt++;
                    end
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkRAM);
        #1;
    endtask

    // Waits (bounded) for an ack; counts sampled cycles with CS high on the way.
    task automatic waitAck(output logic [2:0] ack, output logic [7:0] rdata, output int csCycles);
        int k;
        ack      = 3'b000;
        rdata    = 8'h00;
        csCycles = 0;
        k        = 0;
        while (ack == 3'b000 && k < 1000) begin
            tick(1);
            k++;
            if (o_ack != 3'b000) begin
                ack   = o_ack;
                rdata = o_rdata;
            end else if (o_mem_cs) begin
                csCycles++;
            end
        end
        if (ack == 3'b000)
            check("ack_timeout", 32'd0, 32'd1);
    endtask

    logic [2:0] ack;
    logic [7:0] rdata;
    int         csCycles;
    int         cnt;
    logic [2:0] seqA [3];
    logic [2:0] seqB [6];

    initial begin
        seqA = '{3'b001, 3'b010, 3'b100};
        seqB = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};

        // Reset state
        tick(3);
        check("rst_grant", 32'(o_grant), 32'd3);
        check("rst_ack",   32'(o_ack), 32'd0);
        check("rst_cs",    32'(o_mem_cs), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_rdata", 32'(o_rdata), 32'd0);
        check("rst_addr",  32'(o_mem_addr), 32'd0);
        reset = 1'b0;
        tick(2);

        // Single write from port 1
        mdlLen     = 40;
        i_write[1] = 1'b1;
        i_bank[11:6]   = 6'd0;
        i_addr[31:16]  = 16'd49152;
        i_wdata[15:8]  = 8'hAA;
        i_req[1]   = 1'b1;
        tick(1);
        check("wr_cs_early", 32'(o_mem_cs), 32'd0);
        tick(1);
        check("wr_cs_on",    32'(o_mem_cs), 32'd1);
        check("wr_grant",    32'(o_grant), 32'd1);
        check("wr_addr",     32'(o_mem_addr), 32'd49152);
        check("wr_data",     32'(o_mem_data), 32'hAA);
        check("wr_dir",      32'(o_mem_write), 32'd1);
        waitAck(ack, rdata, csCycles);
        i_req[1] = 1'b0;
        check("wr_ack",   32'(ack), 32'b010);
        check("wr_error", 32'(o_error), 32'd0);
        tick(1);
        check("wr_ack_one_cycle", 32'(o_ack), 32'd0);

        // Read from port 2; its address changes after the grant and must not leak through
        mdlLen        = 10;
        mdlData       = 8'h5A;
        i_write[2]    = 1'b0;
        i_addr[47:32] = 16'h1234;
        i_req[2]      = 1'b1;
        tick(2);
        i_addr[47:32] = 16'hBEEF;
        waitAck(ack, rdata, csCycles);
        i_req[2] = 1'b0;
        check("rd_ack",   32'(ack), 32'b100);
        check("rd_data",  32'(rdata), 32'h5A);
        check("rd_addr",  32'(o_mem_addr), 32'h1234);
        check("rd_dir",   32'(o_mem_write), 32'd0);

        // All three at once, each dropping after its ack: 0, 1, 2
        mdlLen = 5;
        i_req  = 3'b111;
        for (int i = 0; i < 3; i++) begin
            waitAck(ack, rdata, csCycles);
            i_req = i_req & ~ack;
            check($sformatf("prio_%0d", i), 32'(ack), 32'(seqA[i]));
        end

        // Port 0 repeats twice and wins, then ports 1/2 alternate while both held
        i_req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            waitAck(ack, rdata, csCycles);
            if (i == 1) i_req[0] = 1'b0;
            if (i == 5) i_req = 3'b000;
            check($sformatf("rr_%0d", i), 32'(ack), 32'(seqB[i]));
        end
        tick(2);

        // Controller held busy after reset: no CS until it releases
        reset     = 1'b1;
        forceBusy = 1'b1;
        tick(2);
        reset = 1'b0;
        i_req = 3'b101;
        cnt   = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (o_mem_cs || o_grant != 2'd3) cnt++;
        end
        check("busy_no_grant", 32'(cnt), 32'd0);
        forceBusy = 1'b0;
        waitAck(ack, rdata, csCycles);
        i_req[0] = 1'b0;
        check("busy_first", 32'(ack), 32'b001);
        waitAck(ack, rdata, csCycles);
        i_req = 3'b000;
        check("busy_second", 32'(ack), 32'b100);
        tick(2);

        // Controller never accepts: timeout abort
        mdlNever   = 1'b1;
        i_write[1] = 1'b0;
        i_req[1]   = 1'b1;
        waitAck(ack, rdata, csCycles);
        i_req[1] = 1'b0;
        check("to_cs_cycles", 32'(csCycles), 32'(TIMEOUT));
        check("to_ack",       32'(ack), 32'b010);
        check("to_rdata",     32'(rdata), 32'hFF);
        check("to_error",     32'(o_error), 32'd1);
        mdlNever   = 1'b0;
        i_write[2] = 1'b1;
        i_req[2]   = 1'b1;
        waitAck(ack, rdata, csCycles);
        i_req[2] = 1'b0;
        check("to_after_ack",   32'(ack), 32'b100);
        check("to_error_stick", 32'(o_error), 32'd1);
        tick(2);

        // Reset in WAIT_DONE: aborted access is never acked
        mdlLen     = 40;
        i_write[1] = 1'b0;
        i_req[1]   = 1'b1;
        cnt        = 0;
        while (!i_mem_busy && cnt < 50) begin
            tick(1);
            cnt++;
        end
        check("rst_mid_busy_seen", 32'(i_mem_busy), 32'd1);
        tick(2);
        reset = 1'b1;
        i_req = 3'b000;
        tick(1);
        check("rst_mid_cs",    32'(o_mem_cs), 32'd0);
        check("rst_mid_ack",   32'(o_ack), 32'd0);
        check("rst_mid_grant", 32'(o_grant), 32'd3);
        check("rst_mid_error", 32'(o_error), 32'd0);
        reset = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (o_ack != 3'b000) cnt++;
        end
        check("rst_mid_no_ack", 32'(cnt), 32'd0);
        mdlLen     = 6;
        mdlData    = 8'h77;
        i_write[2] = 1'b0;
        i_req[2]   = 1'b1;
        waitAck(ack, rdata, csCycles);
        i_req[2] = 1'b0;
        check("rst_mid_fresh_ack",   32'(ack), 32'b100);
        check("rst_mid_fresh_rdata", 32'(rdata), 32'h77);

        tick(2);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
